// File: rtl/mem_access_ctrl_if.sv
// Bundles the request/response handshake and RAM-side signals of mem_access_ctrl.
// slave: the controller's view. master: the requester plus RAM model view.
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [1:0]  req_mode;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata_hi;
  logic [31:0] req_wdata_lo;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_data_hi;
  logic [31:0] rsp_data_lo;
  logic        ram_enable;
  logic        ram_rw;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic [1:0]  ram_mode;
  logic [31:0] ram_dout;

  modport slave (
    input  req_valid, req_rw, req_mode, req_signed, req_addr, req_wdata_hi, req_wdata_lo,
    input  ram_dout,
    output req_ready, rsp_valid, rsp_err, rsp_data_hi, rsp_data_lo,
    output ram_enable, ram_rw, ram_addr, ram_din, ram_mode
  );

  modport master (
    output req_valid, req_rw, req_mode, req_signed, req_addr, req_wdata_hi, req_wdata_lo,
    output ram_dout,
    input  req_ready, rsp_valid, rsp_err, rsp_data_hi, rsp_data_lo,
    input  ram_enable, ram_rw, ram_addr, ram_din, ram_mode
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage access sequencer for a big-endian byte-addressed data RAM.
// Accepts one load/store at a time, checks range (and optionally alignment),
// splits doublewords into two word accesses, returns extended load data.
// Optional feature macro: MEM_ACCESS_ALIGN_CHECK_EN -- when defined, misaligned
// requests are rejected; otherwise the address is silently aligned down.
module mem_access_ctrl #(
  parameter int unsigned ADDR_LIMIT = 256
) (
  input  logic             clk,
  input  logic             reset,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ISSUE0, CAPT0, ISSUE1, CAPT1, RESP} state_t;

  state_t      state_q, state_d;

  logic        rw_q, signed_q;
  logic [1:0]  mode_q;
  logic [31:0] addr_q, wdata_hi_q, wdata_lo_q;

  logic        ready_q, valid_q, err_q, enable_q, ram_rw_q;
  logic [1:0]  ram_mode_q;
  logic [31:0] ram_addr_q, ram_din_q, data_hi_q, data_lo_q;

  logic        ready_d, valid_d, err_d, enable_d, ram_rw_d;
  logic [1:0]  ram_mode_d;
  logic [31:0] ram_addr_d, ram_din_d, data_hi_d, data_lo_d;

  logic        accept, req_err, misalign;
  logic [31:0] addr_eff;
  logic [32:0] size, last;

  logic        src_rw;
  logic [1:0]  src_mode;
  logic [31:0] src_addr, src_hi, src_lo;

  assign accept = (state_q == IDLE) && bus.req_valid;

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] m, input logic s);
    case (m)
      2'b00:   extend = s ? {{24{d[7]}}, d[7:0]}   : {24'h0, d[7:0]};
      2'b01:   extend = s ? {{16{d[15]}}, d[15:0]} : {16'h0, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  // Request check: effective address, misalignment and 33-bit range test
  always_comb begin
    size     = 33'd1;
    addr_eff = bus.req_addr;
    misalign = 1'b0;
    case (bus.req_mode)
      2'b01:   size = 33'd2;
      2'b10:   size = 33'd4;
      2'b11:   size = 33'd8;
      default: size = 33'd1;
    endcase
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    case (bus.req_mode)
      2'b01:   misalign = bus.req_addr[0];
      2'b10:   misalign = |bus.req_addr[1:0];
      2'b11:   misalign = |bus.req_addr[2:0];
      default: misalign = 1'b0;
    endcase
`else
    case (bus.req_mode)
      2'b01:   addr_eff[0]   = 1'b0;
      2'b10:   addr_eff[1:0] = '0;
      2'b11:   addr_eff[2:0] = '0;
      default: addr_eff      = bus.req_addr;
    endcase
`endif
    last    = {1'b0, addr_eff} + size - 33'd1;
    req_err = misalign || (last >= 33'(ADDR_LIMIT));
  end

  // State register, registered outputs and request latch
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      enable_q   <= 1'b0;
      ram_rw_q   <= 1'b0;
      ram_mode_q <= '0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      data_hi_q  <= '0;
      data_lo_q  <= '0;
      rw_q       <= 1'b0;
      signed_q   <= 1'b0;
      mode_q     <= '0;
      addr_q     <= '0;
      wdata_hi_q <= '0;
      wdata_lo_q <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      enable_q   <= enable_d;
      ram_rw_q   <= ram_rw_d;
      ram_mode_q <= ram_mode_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      data_hi_q  <= data_hi_d;
      data_lo_q  <= data_lo_d;
      if (accept) begin
        rw_q       <= bus.req_rw;
        signed_q   <= bus.req_signed;
        mode_q     <= bus.req_mode;
        addr_q     <= addr_eff;
        wdata_hi_q <= bus.req_wdata_hi;
        wdata_lo_q <= bus.req_wdata_lo;
      end
    end
  end

  // Next-state sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = req_err ? RESP : ISSUE0;
      ISSUE0:  state_d = CAPT0;
      CAPT0:   state_d = (mode_q == 2'b11) ? ISSUE1 : RESP;
      ISSUE1:  state_d = CAPT1;
      CAPT1:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output values for the coming state; on the accept edge the request
  // fields are taken straight from the bus since the latch updates together
  // with the outputs.
  always_comb begin
    src_rw   = accept ? bus.req_rw       : rw_q;
    src_mode = accept ? bus.req_mode     : mode_q;
    src_addr = accept ? addr_eff         : addr_q;
    src_hi   = accept ? bus.req_wdata_hi : wdata_hi_q;
    src_lo   = accept ? bus.req_wdata_lo : wdata_lo_q;

    ready_d    = (state_d == IDLE);
    valid_d    = (state_d == RESP);
    err_d      = (state_q == IDLE) && (state_d == RESP);
    enable_d   = (state_d == ISSUE0) || (state_d == ISSUE1);
    ram_rw_d   = 1'b0;
    ram_addr_d = '0;
    ram_din_d  = '0;
    ram_mode_d = '0;
    case (state_d)
      ISSUE0, CAPT0: begin
        ram_rw_d   = src_rw;
        ram_addr_d = src_addr;
        ram_din_d  = src_hi;
        ram_mode_d = (src_mode == 2'b11) ? 2'b10 : src_mode;
      end
      ISSUE1, CAPT1: begin
        ram_rw_d   = src_rw;
        ram_addr_d = src_addr + 32'd4;
        ram_din_d  = src_lo;
        ram_mode_d = 2'b10;
      end
      default: ;
    endcase

    data_hi_d = data_hi_q;
    data_lo_d = data_lo_q;
    if (accept) begin
      data_hi_d = '0;
      data_lo_d = '0;
    end
    if (state_q == CAPT0 && !rw_q) data_hi_d = extend(bus.ram_dout, mode_q, signed_q);
    if (state_q == CAPT1 && !rw_q) data_lo_d = bus.ram_dout;
  end

  assign bus.req_ready   = ready_q;
  assign bus.rsp_valid   = valid_q;
  assign bus.rsp_err     = err_q;
  assign bus.rsp_data_hi = data_hi_q;
  assign bus.rsp_data_lo = data_lo_q;
  assign bus.ram_enable  = enable_q;
  assign bus.ram_rw      = ram_rw_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_din     = ram_din_q;
  assign bus.ram_mode    = ram_mode_q;

endmodule
